// File: rtl/seq_divider.sv
// Multicycle unsigned restoring divider, one quotient bit per clock.
// The packed {quotient, remainder} result drives the 16-bit num input of the seven-segment display.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result,
  output logic               dbg_state
);

  // Handshake: start is sampled only while idle (busy=0); an accepted start
  // is answered by exactly one done pulse, and start while busy is dropped.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;
  logic             last_step;
  logic             divisor_zero;

  assign divisor_zero = (divisor == '0);
  assign last_step    = (count == CW'(1));

  // Trial subtract is WIDTH+1 bits wide so the bit shifted out of R is never lost.
  always_comb begin
    trial  = {r_reg, q_reg[WIDTH-1]};
    diff   = trial[WIDTH-1:0] - d_reg;
    q_step = {q_reg[WIDTH-2:0], 1'b0};
    r_step = trial[WIDTH-1:0];
    if (trial >= {1'b0, d_reg}) begin
      q_step = {q_reg[WIDTH-2:0], 1'b1};
      r_step = diff;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !divisor_zero) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= CW'(WIDTH);
            // Division by zero completes at once with the conventional all-ones quotient.
            if (divisor_zero) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end
          end
        end
        RUN: begin
          q_reg <= q_step;
          r_reg <= r_step;
          count <= count - CW'(1);
          if (last_step) begin
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            quotient    <= q_step;
            remainder   <= r_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign result    = {quotient, remainder};
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed vectors, boundary cases and an
// operand sweep checked against the division invariant.
module tb_seq_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic [15:0] result;
  logic        dbg_state;

  int vectors;
  int miscompares;
  int done_seen;
  int exp_dones;
  int bc;
  bit gd;

  seq_divider #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .result      (result),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    if (done === 1'b1) done_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the accepting edge; returns at the negedge of the done cycle.
  task automatic wait_done(output int busy_cycles, output bit got_done);
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      @(negedge clock);
    end
    check("done_timeout", 32'(got_done), 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int busy_cycles, output bit got_done);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_dones++;
    wait_done(busy_cycles, got_done);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    vectors     = 0;
    miscompares = 0;
    done_seen   = 0;
    exp_dones   = 0;
    reset       = 1'b1;
    start       = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // 100 / 7
    run_op(8'd100, 8'd7, bc, gd);
    check("t1_busy_len", 32'(bc), 32'd8);
    check("t1_quot", 32'(quotient), 32'h0E);
    check("t1_rem", 32'(remainder), 32'h02);
    check("t1_result", 32'(result), 32'h0E02);
    check("t1_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_hold", 32'(result), 32'h0E02);

    // 255 / 1 with start held into the done cycle, then 5 / 9 accepted there
    dividend = 8'd255;
    divisor  = 8'd1;
    start    = 1'b1;
    @(negedge clock);
    exp_dones++;
    wait_done(bc, gd);
    check("t2a_busy_len", 32'(bc), 32'd8);
    check("t2a_quot", 32'(quotient), 32'hFF);
    check("t2a_rem", 32'(remainder), 32'h00);
    dividend = 8'd5;
    divisor  = 8'd9;
    @(negedge clock);
    start = 1'b0;
    exp_dones++;
    check("t2b_accepted", 32'(busy), 32'd1);
    wait_done(bc, gd);
    check("t2b_busy_len", 32'(bc), 32'd8);
    check("t2b_quot", 32'(quotient), 32'h00);
    check("t2b_rem", 32'(remainder), 32'h05);
    check("t2b_result", 32'(result), 32'h0005);

    // 42 / 0
    run_op(8'd42, 8'd0, bc, gd);
    check("t3_busy_len", 32'(bc), 32'd0);
    check("t3_dbz", 32'(div_by_zero), 32'd1);
    check("t3_quot", 32'(quotient), 32'hFF);
    check("t3_rem", 32'(remainder), 32'h2A);
    check("t3_result", 32'(result), 32'hFF2A);
    @(negedge clock);
    check("t3_done_pulse", 32'(done), 32'd0);
    check("t3_dbz_hold", 32'(div_by_zero), 32'd1);
    check("t3_busy_low", 32'(busy), 32'd0);
    run_op(8'd9, 8'd3, bc, gd);
    check("t3b_dbz_clr", 32'(div_by_zero), 32'd0);
    check("t3b_quot", 32'(quotient), 32'd3);
    check("t3b_rem", 32'(remainder), 32'd0);

    // 200 / 13 with a 1 / 1 start pulsed on busy cycle 3
    @(negedge clock);
    dividend = 8'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_dones++;
    @(negedge clock);
    @(negedge clock);
    check("t4_busy_c3", 32'(busy), 32'd1);
    dividend = 8'd1;
    divisor  = 8'd1;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    wait_done(bc, gd);
    check("t4_busy_rest", 32'(bc), 32'd5);
    check("t4_quot", 32'(quotient), 32'h0F);
    check("t4_rem", 32'(remainder), 32'h05);
    @(negedge clock);
    check("t4_no_restart", 32'(busy), 32'd0);

    // 200 / 13 aborted by reset on busy cycle 4
    dividend = 8'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_result", 32'(result), 32'd0);
    run_op(8'd60, 8'd7, bc, gd);
    check("t5b_busy_len", 32'(bc), 32'd8);
    check("t5b_quot", 32'(quotient), 32'd8);
    check("t5b_rem", 32'(remainder), 32'd4);

    // Operand sweep against the division invariant
    for (int n = 0; n < 2000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, bc, gd);
      check("sw_busy_len", 32'(bc), 32'd8);
      check("sw_invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check("sw_rem_lt_div", 32'(remainder < b), 32'd1);
    end

    repeat (3) @(negedge clock);
    #1;
    check("done_count", 32'(done_seen), 32'(exp_dones));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
